rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one N-to-1 data mux between N_REQ requesters using valid/ready handshakes. It selects one requester per transfer and registers the selected word into a single output stage. The output holds stable until the downstream sink accepts it. It sits between multiple producers and one shared consumer; the mux select is produced internally from the grant.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16, power of two not required
W, 8, data width per requester
IDX_W, $clog2(N_REQ), width of the source index (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester valid; bit i belongs to requester i
req_data  input  N_REQ*W  packed data; requester i occupies bits [i*W +: W]
req_ready  output  N_REQ  per-requester accept, one-hot or zero
out_valid  output  1  output register holds a word
out_data  output  W  registered selected word
out_src  output  IDX_W  index of the requester that supplied out_data
out_ready  input  1  downstream accepts the word when out_valid & out_ready

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0. While rst=1, req_ready is all-zero combinationally. Reset mid-transfer discards the held word; no handshake completes in the reset cycle.
- Two states, encoded by out_valid: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = ~out_valid | out_ready. This is combinational; the output stage can accept a new word this cycle.
- Winner selection: the first i with req_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1. This is purely combinational from req_valid and ptr.
- req_ready[winner]=1 only when load=1 and at least one req_valid is set. All other bits are 0. req_ready never depends on req_ready.
- On a clk edge with load=1 and a winner:
  - out_data <= req_data[winner], out_src <= winner, out_valid <= 1.
  - ptr <= winner+1, wrapping from N_REQ-1 to 0.
- On a clk edge with load=1 and no req_valid: out_valid <= 0. out_data and out_src hold their last values. ptr is unchanged.
- On a clk edge with load=0 (FULL and out_ready=0): all registers hold. out_data and out_src must be bit-stable while out_valid=1 and out_ready=0.
- Latency: one cycle from the handshake req_valid[i]&req_ready[i] to out_valid=1.
- Throughput: one word per cycle when out_ready is held at 1 (drain and refill in the same cycle).
- Fairness: a requester holding valid continuously is granted within N_REQ transfers.
- Protocol: requesters hold req_valid and req_data stable until they see req_ready. A requester dropping valid early just loses arbitration; there is no error signalling.
- A single active requester is granted on every available cycle, regardless of ptr.
- Simultaneous drain and refill: the old word completes on this edge and the new word is loaded on the same edge. No bubble, no duplication.
- No combinational path from out_ready to out_data. The path from out_ready to req_ready is allowed and expected.

Decomposition:
- Shared package rr_arb_pkg holds:
  - default N_REQ and W constants;
  - function next_idx(idx, n) for the wrap-around increment;
  - typedef of the index type.
- Sub-module rr_priority_pick: a combinational round-robin search. Inputs are req vector and ptr. Outputs are found and winner index. It is implemented as a double-width request vector masked by ptr.
- The top level holds the ptr, output register and handshake logic. Data selection reuses the team's mux module, or an indexed part-select driven by winner.

Test Plan:
- Reset: drive rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0000, out_valid=0, out_data=0, out_src=0 throughout. First grant after release goes to requester 0.
- Full contention: req_valid=1111, data i = 8'hA0+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 and out_data A0..A3 repeating. One req_ready bit high per cycle.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises with out_data=8'hA1 -> out_data/out_src stable and req_ready=0000 for all 5 cycles. On out_ready=1, the next grant goes to ptr (requester 2) with refill in the same cycle.
- Single requester: only req_valid[2]=1, out_ready=1 -> requester 2 granted every cycle, out_src=2 continuously, ptr settles at 3.
- Idle gap: a single grant to requester 3, then req_valid=0000 -> out_valid falls one cycle after the drain. The next request on 1 and 0 together gives requester 0 (ptr wrapped to 0).
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 next edge, ptr=0, and the held word is never accepted.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, index type and wrap-around helper for the round-robin mux arbiter.
package rr_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;
  localparam int MAX_IDX_W = 4;

  typedef logic [MAX_IDX_W-1:0] idx_t;

  function automatic idx_t next_idx(idx_t idx, int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_winner
);

  logic [2*N-1:0] w_dbl;

  // Lower copy masked below ptr, upper copy covers the wrap back to 0.
  assign w_dbl = {i_req, i_req} & ({(2*N){1'b1}} << i_ptr);

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        o_found  = 1'b1;
        o_winner = IDX_W'(j % N);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N-to-1 data mux, with a single registered output stage.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_src,
  input  logic               out_ready
);

  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [IDX_W-1:0] r_src;
  logic [IDX_W-1:0] r_ptr;

  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [W-1:0]     w_sel_data;

  assign w_load = ~r_valid | out_ready;

  rr_priority_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IDX_W'(i)) w_sel_data = req_data[i*W +: W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && w_load && w_found) req_ready[w_winner] = 1'b1;
  end

  // EMPTY/FULL is carried entirely by r_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_src   <= w_winner;
        r_ptr   <= IDX_W'(next_idx(idx_t'(w_winner), N_REQ));
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_ptr   = 0;
  bit         m_valid = 0;
  logic [7:0] m_data  = '0;
  logic [1:0] m_src   = '0;

  localparam logic [N*W-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  rr_mux_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_winner();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = exp_winner();
    if (rst || !(!m_valid || out_ready) || w < 0) return '0;
    return N'(1 << w);
  endfunction

  task automatic set_in(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] d, input bit ordy);
    @(negedge clk);
    rst = r; req_valid = v; req_data = d; out_ready = ordy;
    #1;
  endtask

  // advance one edge and update the model with the inputs present at that edge
  task automatic tick();
    int w;
    @(posedge clk);
    w = exp_winner();
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = '0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (w >= 0) begin
        m_valid = 1; m_data = req_data[w*W +: W]; m_src = 2'(w); m_ptr = (w + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic do_reset();
    set_in(1, '0, '0, 0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1, 4'b1111, DATA_A, 1);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, req_ready);
      end
      tick();
      #1;
      checks++;
      if ({out_valid, out_data, out_src} !== 11'd0) begin
        failures++; $display("FAIL reset_out cyc=%0d got v=%b d=%h s=%0d exp all zero", c, out_valid, out_data, out_src);
      end
    end
    set_in(0, 4'b1111, DATA_A, 1);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hA0) begin
      failures++; $display("FAIL reset_first_out got v=%b s=%0d d=%h exp v=1 s=0 d=a0", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(0, 4'b1111, DATA_A, 1);
      checks++;
      if (req_ready !== 4'(1 << (k % 4)) || req_ready !== exp_ready()) begin
        failures++; $display("FAIL contention_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
      #1;
      checks++;
      if (out_src !== 2'(k % 4) || out_data !== 8'(8'hA0 + k % 4) || out_valid !== 1'b1) begin
        failures++; $display("FAIL contention_out k=%0d got s=%0d d=%h v=%b exp s=%0d", k, out_src, out_data, out_valid, k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(0, 4'b1111, DATA_A, 1); tick();
    set_in(0, 4'b1111, DATA_A, 1); tick();
    for (int c = 0; c < 5; c++) begin
      set_in(0, 4'b1111, DATA_A, 0);
      checks++;
      if (req_ready !== 4'b0000 || out_data !== 8'hA1 || out_src !== 2'd1 || out_valid !== 1'b1) begin
        failures++; $display("FAIL backpressure_hold c=%0d got rdy=%b d=%h s=%0d v=%b exp rdy=0000 d=a1 s=1 v=1",
                             c, req_ready, out_data, out_src, out_valid);
      end
      tick();
    end
    set_in(0, 4'b1111, DATA_A, 1);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL backpressure_release got=%b exp=0100", req_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'hA2) begin
      failures++; $display("FAIL backpressure_refill got v=%b s=%0d d=%h exp v=1 s=2 d=a2", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(0, 4'b0100, DATA_A, 1);
      checks++;
      if (req_ready !== 4'b0100) begin
        failures++; $display("FAIL single_ready c=%0d got=%b exp=0100", c, req_ready);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || m_ptr != 3) begin
        failures++; $display("FAIL single_out c=%0d got v=%b s=%0d exp v=1 s=2", c, out_valid, out_src);
      end
    end
  endtask

  task automatic test_idle_gap();
    do_reset();
    set_in(0, 4'b1000, DATA_A, 1); tick();
    set_in(0, 4'b0000, DATA_A, 1);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd3 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL idle_grant3 got v=%b s=%0d rdy=%b exp v=1 s=3 rdy=0000", out_valid, out_src, req_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd3 || out_data !== 8'hA3) begin
      failures++; $display("FAIL idle_drain got v=%b s=%0d d=%h exp v=0 s=3 d=a3", out_valid, out_src, out_data);
    end
    set_in(0, 4'b0011, DATA_A, 1);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL idle_wrap got=%b exp=0001", req_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      failures++; $display("FAIL idle_wrap_out got v=%b s=%0d exp v=1 s=0", out_valid, out_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(0, 4'b0010, DATA_A, 1); tick();
    set_in(1, 4'b1111, DATA_A, 0);
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_ready got rdy=%b v=%b exp rdy=0000 v=1", req_ready, out_valid);
    end
    tick();
    #1;
    checks++;
    if ({out_valid, out_data, out_src} !== 11'd0) begin
      failures++; $display("FAIL midreset_out got v=%b d=%h s=%0d exp all zero", out_valid, out_data, out_src);
    end
    set_in(0, 4'b1111, DATA_A, 1);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL midreset_ptr got=%b exp=0001", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom_range(0, 49) == 0), 4'($urandom), {$urandom}, ($urandom_range(0, 3) != 0));
      checks++;
      if (req_ready !== exp_ready() || out_valid !== m_valid || out_data !== m_data || out_src !== m_src) begin
        failures++;
        $display("FAIL random c=%0d got rdy=%b v=%b d=%h s=%0d exp rdy=%b v=%b d=%h s=%0d",
                 c, req_ready, out_valid, out_data, out_src, exp_ready(), m_valid, m_data, m_src);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    test_reset();
    test_contention();
    test_backpressure();
    test_single();
    test_idle_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
